// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types for the instruction/data memory port arbiter.
//   arb_state_t : arbiter transaction state (IDLE, REQ, WAIT)
//   owner_t     : which core port owns the memory (INSTR=0, DATA=1)
//   other_owner : returns the opposite requester, used by round-robin tie break
// Configuration macro: ARB_RR_EN (round-robin tie break, see arb_prio_sel).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no transaction, winner chosen combinationally
    ST_REQ  = 2'd1,  // request presented, owner locked, awaiting mem_gnt
    ST_WAIT = 2'd2   // request granted, awaiting mem_r_valid
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// -----------------------------------------------------------------------------
// arb_prio_sel
//
// Combinational two-way selector between the instruction and data requesters.
// A lone requester always wins. On a tie:
//   ARB_RR_EN defined   : the requester that did not own the last completed
//                         transaction wins.
//   ARB_RR_EN undefined : data wins; last_owner is not used.
// With neither request active the output defaults to OWN_INSTR (don't care).
//
// Ports:
//   instr_req  in   instruction-fetch request
//   data_req   in   load/store request
//   last_owner in   owner of the most recently completed transaction
//   winner     out  selected requester
// -----------------------------------------------------------------------------
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic   instr_req,
  input  logic   data_req,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = OWN_INSTR;
    if (instr_req && data_req) begin
`ifdef ARB_RR_EN
      winner = other_owner(last_owner);
`else
      winner = OWN_DATA;
`endif
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end

`ifndef ARB_RR_EN
  // Fixed priority ignores history; keep the port so both builds share a shape.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch port and the
// data (load/store) port. The selected requester is locked for the whole
// transaction (request through response) and the response is routed back to
// it. Grants and response valids are combinational pass-throughs, so a
// granted request sees no added latency. At most one transaction is
// outstanding; a response in WAIT returns to IDLE, so the next request is
// presented one cycle later.
//
// Configuration macro: ARB_RR_EN -- round-robin tie break instead of the
// default fixed priority (data wins ties). Without it no last_owner register
// exists.
//
// Handshake semantics (all ports): a requester raises *_req with stable
// address/control and holds it until the cycle in which *_gnt is high; that
// cycle is the acceptance. Exactly one *_r_valid pulse follows each accepted
// request (writes included). The memory side obeys the same rules with
// mem_req/mem_gnt/mem_r_valid.
//
// Ports:
//   CLK, RES                       clock, asynchronous active-high reset
//   instr_req/addr                 fetch request in
//   instr_gnt/r_valid/rdata        fetch handshake out
//   data_req/addr/we/be/wdata      load/store request in
//   data_gnt/r_valid/rdata         load/store handshake out
//   mem_req/addr/we/be/wdata       memory request out
//   mem_gnt/r_valid/rdata          memory handshake in
//   spurious_rvalid                sticky: mem_r_valid seen outside WAIT
//   dbg_state                      current arbiter state
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RES,
  // instruction port
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic                instr_gnt,
  output logic                instr_r_valid,
  output logic [DATA_W-1:0]   instr_rdata,
  // data port
  input  logic                data_req,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_r_valid,
  output logic [DATA_W-1:0]   data_rdata,
  // memory port
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_r_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status / debug
  output logic                spurious_rvalid,
  output arb_state_t          dbg_state
);

  arb_state_t state_q;
  owner_t     owner_q;
  owner_t     last_owner;
  owner_t     winner;
  owner_t     sel_owner;
  logic       spurious_q;
  logic       any_req;
  logic       owner_req;
  logic       present;
  logic       resp;

`ifdef ARB_RR_EN
  owner_t last_owner_q;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_INSTR;
`endif

  arb_prio_sel u_sel (
    .instr_req  (instr_req),
    .data_req   (data_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // Request path: IDLE presents the fresh winner, REQ only the locked owner.
  always_comb begin
    any_req   = instr_req | data_req;
    owner_req = (owner_q == OWN_DATA) ? data_req : instr_req;
    sel_owner = (state_q == ST_IDLE) ? winner : owner_q;
    present   = 1'b0;
    case (state_q)
      ST_IDLE: present = any_req;
      ST_REQ:  present = owner_req;
      default: present = 1'b0;
    endcase
    // State already reads IDLE under reset; also suppress the live request.
    if (RES) present = 1'b0;
  end

  assign mem_req   = present;
  assign mem_addr  = (sel_owner == OWN_DATA) ? data_addr  : instr_addr;
  assign mem_we    = (sel_owner == OWN_DATA) ? data_we    : 1'b0;
  assign mem_be    = (sel_owner == OWN_DATA) ? data_be    : '1;
  assign mem_wdata = (sel_owner == OWN_DATA) ? data_wdata : '0;

  assign instr_gnt = present & mem_gnt & (sel_owner == OWN_INSTR);
  assign data_gnt  = present & mem_gnt & (sel_owner == OWN_DATA);

  // Response path: only a response in WAIT belongs to a transaction.
  assign resp          = (state_q == ST_WAIT) & mem_r_valid & ~RES;
  assign instr_r_valid = resp & (owner_q == OWN_INSTR);
  assign data_r_valid  = resp & (owner_q == OWN_DATA);
  assign instr_rdata   = mem_rdata;
  assign data_rdata    = mem_rdata;

  assign spurious_rvalid = spurious_q;
  assign dbg_state       = state_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INSTR;
      spurious_q <= 1'b0;
`ifdef ARB_RR_EN
      last_owner_q <= OWN_INSTR;
`endif
    end else begin
      if (mem_r_valid && (state_q != ST_WAIT)) spurious_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            state_q <= mem_gnt ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          // Owner withdrawing its request abandons the attempt.
          if (!owner_req)   state_q <= ST_IDLE;
          else if (mem_gnt) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_r_valid) begin
            state_q <= ST_IDLE;
`ifdef ARB_RR_EN
            last_owner_q <= owner_q;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the instruction-fetch port and the data (load/store) port of the control unit. It sits between the core's req/gnt/r_valid handshake ports and the unified memory, locks the selected requester for the full transaction, and routes the response back to the owner. The arbiter holds at most one transaction outstanding and adds no latency to a granted request.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CLK  in  1  clock, all state on rising edge
- RES  in  1  reset, asynchronous, active-high
- instr_req  in  1  fetch request, held by requester until instr_gnt
- instr_addr  in  ADDR_W  fetch address
- instr_gnt  out  1  fetch request accepted
- instr_r_valid  out  1  fetch data valid
- instr_rdata  out  DATA_W  fetch data (broadcast of mem_rdata)
- data_req  in  1  data request, held until data_gnt
- data_addr  in  ADDR_W  data address
- data_we  in  1  1 = write, 0 = read
- data_be  in  DATA_W/8  byte enables
- data_wdata  in  DATA_W  write data
- data_gnt  out  1  data request accepted
- data_r_valid  out  1  data response valid (reads and writes)
- data_rdata  out  DATA_W  read data (broadcast of mem_rdata)
- mem_req, mem_addr, mem_we, mem_be, mem_wdata  out  1/ADDR_W/1/DATA_W/8/DATA_W  memory request
- mem_gnt  in  1  memory accepted request
- mem_r_valid  in  1  memory response valid; exactly one per granted transaction, including writes
- mem_rdata  in  DATA_W  memory read data
- spurious_rvalid  out  1  sticky flag: mem_r_valid seen with no transaction outstanding

## Operation
- States: IDLE, REQ (request presented, owner locked, awaiting mem_gnt), WAIT (granted, awaiting mem_r_valid).
- IDLE: if any req, select winner combinationally, drive mem_* from winner the same cycle. mem_gnt=1 -> winner's gnt=1, latch owner, go WAIT. mem_gnt=0 -> latch owner, go REQ.
- REQ: mem_* driven from latched owner only; other requester ignored. mem_gnt=1 -> owner gnt, go WAIT. Owner drops req (protocol violation) -> mem_req=0, go IDLE.
- WAIT: mem_req=0; both gnt=0. mem_r_valid=1 -> owner's r_valid=1 same cycle, set last_owner, go IDLE.
- Tie (both req in IDLE): data wins, unless round-robin enabled (see Configuration).
- Non-owner r_valid always 0; rdata broadcast to both ports unconditionally.
- instr port: mem_we=0, mem_be=all ones.
- mem_r_valid in IDLE or REQ: ignored for routing, sets spurious_rvalid (cleared only by RES).

## Timing
- Reset values: state IDLE, owner=INSTR, last_owner=INSTR, spurious_rvalid=0; while RES=1 mem_req, instr_gnt, data_gnt, instr_r_valid, data_r_valid all 0.
- Grant and r_valid paths are combinational pass-through: zero added cycles.
- mem_r_valid in WAIT with a new req pending: new request not presented until following cycle (one bubble between transactions).
- mem_addr/we/be/wdata stable from first mem_req cycle until mem_gnt (owner locked in REQ).
- Reset mid-transaction: outstanding response discarded; a later mem_r_valid arriving in IDLE sets spurious_rvalid.
- Back-to-back from one requester: minimum 2 cycles per transaction (grant cycle, response cycle).

## Configuration
- ARB_RR_EN defined: on tie, grant the requester that is not last_owner; last_owner updates on each completed response.
- ARB_RR_EN undefined: fixed priority, data always wins ties; last_owner register omitted.
- Both modes: since last_owner resets to INSTR, first tie after reset goes to data.

## Structure
- Package mem_arb_pkg: state encoding (IDLE, REQ, WAIT), owner encoding (INSTR=0, DATA=1).
- One sub-module arb_prio_sel: combinational two-way selector (inputs: two reqs, last_owner; output: winner), with ARB_RR_EN handled inside it.

## Test plan
- Data-only read, mem_gnt immediate, mem_r_valid 2 cycles later with rdata=0xDEADBEEF -> data_gnt same cycle as req, data_r_valid=1 with data_rdata=0xDEADBEEF, instr_r_valid stays 0.
- Both req in IDLE, mem_gnt=1 -> data_gnt=1, instr_gnt=0; after response, instr granted next cycle; with ARB_RR_EN a second tie goes to instr.
- mem_gnt held 0 for 3 cycles with instr owner, data_req rises meanwhile -> mem_addr stays instr_addr (e.g. 0x100) all 3 cycles, data not granted until instr completes.
- Data write (we=1, be=4'b0011, wdata=0x1234) -> mem_we=1, mem_be=4'b0011, data_r_valid on write ack.
- mem_r_valid pulsed in IDLE -> spurious_rvalid=1 and stays 1; no r_valid forwarded; RES clears it.
- RES asserted in WAIT -> all gnt/r_valid 0, state IDLE, next request served normally.
